// File: rtl/lsu_bridge.sv
// lsu_bridge: bridges a core load/store request to a single-beat memory
// controller access, checks funct3 legality and alignment, bounds the wait
// for mem_ready with a timeout, and formats load data for the core.
//
// Ports
//   clk, rst       single clock, synchronous active-high reset
//   req_*          core request (valid/ready handshake, we, funct3, addr, wdata)
//   resp_*         one-cycle completion pulse with formatted data and error code
//   mem_*          memory controller side (address, data, size flag, strobes,
//                  read data and ready)
//
// Error codes on resp_err: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
module lsu_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_wflag,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             we_q, we_n;
  logic             req_ready_n, resp_valid_n, mem_we_n, mem_re_n;
  logic [31:0]      resp_rdata_n, mem_addr_n, mem_wdata_n;
  logic [1:0]       resp_err_n;
  logic [2:0]       mem_wflag_n;

  logic             req_illegal, req_misaligned;
  logic [CNT_W:0]   cnt_inc;
  logic             timeout_hit;
  logic [31:0]      load_fmt;

  // Legality and alignment of the incoming request.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_we) begin
      req_illegal = (req_funct3 > 3'b010);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  // Load formatting always works on the low bits of the returned word.
  always_comb begin
    load_fmt = 32'd0;
    case (mem_wflag)
      3'b000:  load_fmt = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_fmt = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b010:  load_fmt = mem_rdata;
      3'b100:  load_fmt = {24'd0, mem_rdata[7:0]};
      3'b101:  load_fmt = {16'd0, mem_rdata[15:0]};
      default: load_fmt = 32'd0;
    endcase
  end

  // Widened increment so the compare against TIMEOUT_CYCLES cannot wrap.
  always_comb begin
    cnt_inc     = {1'b0, cnt} + (CNT_W+1)'(1);
    timeout_hit = (cnt_inc == (CNT_W+1)'(TIMEOUT_CYCLES));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    we_n         = we_q;
    resp_valid_n = 1'b0;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_wflag_n  = mem_wflag;
    mem_we_n     = 1'b0;
    mem_re_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          we_n        = req_we;
          mem_addr_n  = req_addr;
          mem_wdata_n = req_wdata;
          mem_wflag_n = req_funct3;
          if (req_illegal || req_misaligned) begin
            state_n      = S_RESP;
            resp_valid_n = 1'b1;
            resp_rdata_n = 32'd0;
            resp_err_n   = req_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
          end else begin
            state_n  = S_ACCESS;
            cnt_n    = '0;
            mem_we_n = req_we;
            mem_re_n = !req_we;
          end
        end
      end
      S_ACCESS: begin
        cnt_n    = cnt_inc[CNT_W-1:0];
        mem_we_n = mem_we;
        mem_re_n = mem_re;
        // mem_ready takes precedence over a timeout in the same cycle.
        if (mem_ready) begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = we_q ? 32'd0 : load_fmt;
          resp_err_n   = ERR_OK;
          mem_we_n     = 1'b0;
          mem_re_n     = 1'b0;
        end else if (timeout_hit) begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = 32'd0;
          resp_err_n   = ERR_TIMEOUT;
          mem_we_n     = 1'b0;
          mem_re_n     = 1'b0;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    req_ready_n = (state_n == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= ERR_OK;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wflag  <= 3'd0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      we_q       <= we_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_wflag  <= mem_wflag_n;
      mem_we     <= mem_we_n;
      mem_re     <= mem_re_n;
    end
  end

endmodule

// File: tb/tb_lsu_bridge.sv
// tb_lsu_bridge: directed bench for lsu_bridge with a transaction-level
// model of the expected response, latency and memory strobe window, checked
// every cycle, plus literal expectations for the worked examples.
module tb_lsu_bridge;

  localparam int unsigned T = 4;
  localparam int NEVER = -1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_wflag;
  logic        mem_we, mem_re, mem_ready;

  lsu_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wflag(mem_wflag),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Cycle index = number of rising edges seen; in_rst = rst sampled at the last edge.
  int cyc = 0;
  bit in_rst = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    in_rst <= rst;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Expected transaction (one outstanding at a time).
  bit          t_valid = 1'b0;
  int          t_a = NEVER, t_resp = NEVER, t_acc_n = 0, cancel_a = NEVER - 1;
  bit          t_we;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [1:0]  t_err;
  logic [31:0] hold_rdata = 32'd0;
  logic [1:0]  hold_err = 2'd0;

  int          rdy_cyc = NEVER, stray_cyc = NEVER;
  int          acc_cyc = 0, last_resp_cyc = 0, n_resp = 0;
  logic [31:0] last_rdata;
  logic [1:0]  last_err;
  bit          strobe_seen;
  logic [31:0] snap_addr, snap_wdata;
  logic [2:0]  snap_flag;
  logic        snap_we, snap_re;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the transaction model.
  task automatic compare_cycle();
    bit act, busy, exp_valid, in_acc;
    if (in_rst) begin
      cancel_a   = t_a;
      hold_rdata = 32'd0;
      hold_err   = 2'd0;
    end
    act       = t_valid && (cancel_a != t_a);
    busy      = act && (cyc >= t_a) && (cyc <= t_resp);
    exp_valid = act && (cyc == t_resp);
    in_acc    = act && (cyc >= t_a) && (cyc < t_a + t_acc_n);

    chk("req_ready", 32'(req_ready), 32'(!in_rst && !busy));
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    chk("mem_re", 32'(mem_re), 32'(in_acc && !t_we));
    chk("mem_we", 32'(mem_we), 32'(in_acc && t_we));
    if (exp_valid) begin
      hold_rdata = t_rdata;
      hold_err   = t_err;
    end
    chk("resp_rdata", resp_rdata, hold_rdata);
    chk("resp_err", 32'(resp_err), 32'(hold_err));
    if (in_acc) begin
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_wdata", mem_wdata, t_wdata);
      chk("mem_wflag", 32'(mem_wflag), 32'(t_f3));
      if (cyc == t_a) begin
        snap_addr = mem_addr; snap_wdata = mem_wdata; snap_flag = mem_wflag;
        snap_we = mem_we; snap_re = mem_re;
      end
    end
    if (in_rst) begin
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wflag", 32'(mem_wflag), 32'd0);
    end
    if (mem_re === 1'b1 || mem_we === 1'b1) strobe_seen = 1'b1;
    if (resp_valid === 1'b1) begin
      n_resp++;
      last_resp_cyc = cyc;
      last_rdata    = resp_rdata;
      last_err      = resp_err;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    mem_ready = (cyc == rdy_cyc) || (cyc == stray_cyc);
  endtask

  // Expected load result from the RV32I rules, using plain arithmetic.
  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = w % 32'd256;   return (v >= 32'd128)   ? v - 32'd256   : v; end
      3'd1: begin v = w % 32'd65536; return (v >= 32'd32768) ? v - 32'd65536 : v; end
      3'd4: return w % 32'd256;
      3'd5: return w % 32'd65536;
      default: return w;
    endcase
  endfunction

  // Issue one request; delay = ACCESS cycles before mem_ready (<0: never).
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] word,
                         input bit rst_mid, input bit junk);
    int  guard;
    int  a;
    bit  illegal, mis;
    guard = 0;
    tick();
    while (req_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      chk("ready_wait_timeout", 32'd1, 32'd0);
      return;
    end
    a = cyc + 1;
    acc_cyc = cyc;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_rdata = word;
    strobe_seen = 1'b0;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wdata; t_rdata = 32'd0;
    if (illegal || mis) begin
      t_err = illegal ? 2'b11 : 2'b01;
      t_acc_n = 0;
      t_resp = a;
    end else if (delay >= 0 && delay < int'(T)) begin
      t_err = 2'b00;
      t_acc_n = delay + 1;
      t_resp = a + delay + 1;
      t_rdata = we ? 32'd0 : fmt(f3, word);
    end else begin
      t_err = 2'b10;
      t_acc_n = int'(T);
      t_resp = a + int'(T);
    end
    t_a = a;
    t_valid = 1'b1;
    rdy_cyc = (delay >= 0) ? a + delay : NEVER;
    tick();
    req_valid = 1'b0;
    if (junk) begin
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h3000;
    end
    if (rst_mid) rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    while (cyc < a + 10) tick();
  endtask

  initial begin
    int r0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    tick();
    tick();
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_mem_re", 32'(mem_re), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    // LB at 0x2003, ready in the first ACCESS cycle
    run_req(1'b0, 3'd0, 32'h2003, 32'd0, 0, 32'h0000_00F0, 1'b0, 1'b0);
    chk("lb_rdata", last_rdata, 32'hFFFF_FFF0);
    chk("lb_err", 32'(last_err), 32'd0);
    chk("lb_latency", 32'(last_resp_cyc - acc_cyc), 32'd2);

    // SH at 0x2002
    run_req(1'b1, 3'd1, 32'h2002, 32'h1234_ABCD, 2, 32'hAAAA_5555, 1'b0, 1'b0);
    chk("sh_mem_we", 32'(snap_we), 32'd1);
    chk("sh_mem_re", 32'(snap_re), 32'd0);
    chk("sh_wflag", 32'(snap_flag), 32'd1);
    chk("sh_wdata", snap_wdata, 32'h1234_ABCD);
    chk("sh_addr", snap_addr, 32'h2002);
    chk("sh_rdata", last_rdata, 32'd0);
    chk("sh_err", 32'(last_err), 32'd0);

    // Misaligned LW
    run_req(1'b0, 3'd2, 32'h2001, 32'd0, 0, 32'h1111_1111, 1'b0, 1'b0);
    chk("lw_mis_err", 32'(last_err), 32'd1);
    chk("lw_mis_latency", 32'(last_resp_cyc - acc_cyc), 32'd1);
    chk("lw_mis_no_strobe", 32'(strobe_seen), 32'd0);

    // Illegal funct3 (load 011, store 100, illegal beats misaligned)
    run_req(1'b0, 3'd3, 32'h2000, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    chk("ld011_err", 32'(last_err), 32'd3);
    run_req(1'b1, 3'd4, 32'h2000, 32'h55, 0, 32'd0, 1'b0, 1'b0);
    chk("st100_err", 32'(last_err), 32'd3);
    run_req(1'b0, 3'd3, 32'h2001, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    chk("ill_over_mis_err", 32'(last_err), 32'd3);

    // Timeout with a late mem_ready and ignored req_valid while busy
    run_req(1'b0, 3'd2, 32'h2000, 32'd0, 6, 32'hCAFE_F00D, 1'b0, 1'b1);
    chk("timeout_err", 32'(last_err), 32'd2);
    chk("timeout_rdata", last_rdata, 32'd0);
    chk("timeout_latency", 32'(last_resp_cyc - acc_cyc), 32'(T + 1));

    // mem_ready in the last possible ACCESS cycle wins over timeout
    run_req(1'b0, 3'd2, 32'h2004, 32'd0, int'(T) - 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("last_cycle_err", 32'(last_err), 32'd0);
    chk("last_cycle_rdata", last_rdata, 32'hDEAD_BEEF);

    // Load formatting variants
    run_req(1'b0, 3'd1, 32'h2002, 32'd0, 1, 32'h1234_8765, 1'b0, 1'b0);
    chk("lh_rdata", last_rdata, 32'hFFFF_8765);
    run_req(1'b0, 3'd5, 32'h2002, 32'd0, 0, 32'h1234_8765, 1'b0, 1'b0);
    chk("lhu_rdata", last_rdata, 32'h0000_8765);
    run_req(1'b0, 3'd4, 32'h2001, 32'd0, 0, 32'hFFFF_FF80, 1'b0, 1'b0);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);
    run_req(1'b0, 3'd0, 32'h2000, 32'd0, 0, 32'h0000_017F, 1'b0, 1'b0);
    chk("lb_pos_rdata", last_rdata, 32'h0000_007F);

    // Byte and word stores
    run_req(1'b1, 3'd0, 32'h2007, 32'h0000_00AB, 0, 32'd0, 1'b0, 1'b0);
    chk("sb_err", 32'(last_err), 32'd0);
    run_req(1'b1, 3'd2, 32'h2008, 32'h8765_4321, 3, 32'd0, 1'b0, 1'b0);
    chk("sw_wflag", 32'(snap_flag), 32'd2);

    // Reset in the middle of an LHU access, then a clean LHU
    r0 = n_resp;
    run_req(1'b0, 3'd5, 32'h2000, 32'd0, -1, 32'd0, 1'b1, 1'b0);
    chk("rst_mid_no_resp", 32'(n_resp - r0), 32'd0);
    run_req(1'b0, 3'd5, 32'h2000, 32'd0, 0, 32'h0000_FFFF, 1'b0, 1'b0);
    chk("lhu_after_rst", last_rdata, 32'h0000_FFFF);

    // Stray mem_ready while idle
    r0 = n_resp;
    stray_cyc = cyc + 2;
    repeat (6) tick();
    chk("stray_ready_no_resp", 32'(n_resp - r0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_bridge.md
LSU_BRIDGE -- requirements
Module: lsu_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in ACCESS waiting for mem_ready; legal range 1..65535.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core load/store request.
REQ-005 req_ready  output  1  high only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both high.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I funct3 of the load/store.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  formatted load result; 0 for stores and errors.
REQ-012 resp_err  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-013 mem_addr  output  32  byte address to the memory controller.
REQ-014 mem_wdata  output  32  store data to the memory controller, unshifted.
REQ-015 mem_wflag  output  3  store size, equal to the latched funct3.
REQ-016 mem_we  output  1  write strobe.
REQ-017 mem_re  output  1  read strobe.
REQ-018 mem_rdata  input  32  word read at mem_addr; byte 0 of the result is at bits [7:0].
REQ-019 mem_ready  input  1  memory completion, sampled on the rising edge of clk.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP.
REQ-021 IDLE, on accept: latch req_we, req_funct3, req_addr and req_wdata.
REQ-022 Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other funct3 sets err=11 and goes to RESP.
REQ-023 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0, sets err=01 and goes to RESP. Illegal funct3 takes priority over misalignment.
REQ-024 Error requests go IDLE->RESP directly and never assert mem_we or mem_re.
REQ-025 Legal, aligned requests go IDLE->ACCESS.
REQ-026 ACCESS strobes: assert exactly one of mem_we (store) or mem_re (load).
REQ-027 ACCESS outputs: mem_addr, mem_wdata and mem_wflag hold the latched values, stable for the whole state.
REQ-028 ACCESS cycle count: a 16-bit counter clears on entry and increments each cycle.
REQ-029 mem_ready high in ACCESS: capture mem_rdata and go to RESP with err=00.
REQ-030 Timeout: the counter reaches TIMEOUT_CYCLES with mem_ready low -> go to RESP with err=10.
REQ-031 mem_ready and timeout in the same cycle: mem_ready wins (err=00).
REQ-032 mem_we and mem_re drop on the clock edge that leaves ACCESS; both are low in IDLE and RESP.
REQ-033 mem_ready seen outside ACCESS is ignored.
REQ-034 Load formatting uses the captured word's low bits regardless of addr[1:0]:
- LB: sign-extend [7:0]
- LBU: zero-extend [7:0]
- LH: sign-extend [15:0]
- LHU: zero-extend [15:0]
- LW: full 32 bits.
REQ-035 RESP: resp_valid=1 for exactly one cycle with resp_rdata and resp_err valid, then IDLE; there is no back-pressure.
REQ-036 req_ready is low in ACCESS and RESP; req_valid in those states is ignored, not queued.
REQ-037 Latency: accept at edge N, earliest resp_valid in cycle N+2 (mem_ready in the first ACCESS cycle); error requests give resp_valid in cycle N+1.
REQ-038 resp_rdata and resp_err hold their last values outside RESP; only resp_valid qualifies them.

Reset
REQ-039 rst high at a rising edge, in any state including mid-ACCESS: state=IDLE next cycle, and the access is abandoned with no response.
REQ-040 Output values in reset: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=00, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, mem_wflag=000, counter=0.
REQ-041 The first cycle after rst deasserts is IDLE with req_ready=1.

Verification
REQ-042 LB at 0x2003, memory returns 0x000000F0 with mem_ready in the first ACCESS cycle -> resp_rdata=0xFFFFFFF0, err=00, resp_valid exactly two cycles after accept.
REQ-043 SH (funct3 001) at 0x2002, wdata 0x1234ABCD -> mem_we=1, mem_wflag=001, mem_wdata=0x1234ABCD, mem_addr=0x2002; resp_rdata=0, err=00.
REQ-044 LW at 0x2001 -> err=01 one cycle after accept; mem_re never asserted.
REQ-045 Load with funct3=011 -> err=11; store with funct3=100 -> err=11.
REQ-046 TIMEOUT_CYCLES=4, mem_ready held low -> err=10 after 4 ACCESS cycles, mem_re then deasserted; a late mem_ready is ignored.
REQ-047 rst pulsed during ACCESS of an LHU -> no resp_valid; mem_re low next cycle; a following LHU at 0x2000 returning 0x0000FFFF gives resp_rdata=0x0000FFFF.
